// File: rtl/doom_kb_pkg.sv
// Shared scan-code constants, decoder states and arrow flag payload.
package doom_kb_pkg;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXT     = 2'd1,
      BRK     = 2'd2,
      EXT_BRK = 2'd3
   } kb_state_t;

   typedef struct packed {
      logic up;
      logic down;
      logic left;
      logic right;
   } arrow_flags_t;

   // One-hot flag mask for an arrow scan code, zero for anything else.
   function automatic arrow_flags_t arrow_mask(input logic [7:0] code);
      arrow_flags_t m;
      m = '0;
      case (code)
         SC_UP:    m.up    = 1'b1;
         SC_DOWN:  m.down  = 1'b1;
         SC_LEFT:  m.left  = 1'b1;
         SC_RIGHT: m.right = 1'b1;
         default:  m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronizer, falling-edge detect,
// 11-bit frame assembly with odd parity check, and a partial-frame timeout.
module ps2_rx_frame #(
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       kb_clock,
   input  logic       kb_dat,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_error
);

   localparam int unsigned CNT_W =
      ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   clk_prev;
   logic                   clk_s;
   logic                   dat_s;
   logic                   fall;
   logic [3:0]             bit_cnt;
   logic [7:0]             shift;
   logic                   parity;
   logic [CNT_W-1:0]       idle_cnt;

   assign clk_s = clk_sync[SYNC_STAGES-1];
   assign dat_s = dat_sync[SYNC_STAGES-1];
   assign fall  = clk_prev & ~clk_s;

   // Bring the asynchronous PS/2 lines into the clock domain; idle bus is high.
   always_ff @(posedge clock) begin
      if (reset) begin
         clk_sync <= '1;
         dat_sync <= '1;
         clk_prev <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], kb_clock};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], kb_dat};
         clk_prev <= clk_s;
      end
   end

   // Assemble bits on each falling edge; abandon a stalled partial frame.
   always_ff @(posedge clock) begin
      if (reset) begin
         bit_cnt     <= 4'd0;
         shift       <= 8'd0;
         parity      <= 1'b0;
         idle_cnt    <= '0;
         byte_valid  <= 1'b0;
         byte_data   <= 8'd0;
         frame_error <= 1'b0;
      end else begin
         byte_valid  <= 1'b0;
         frame_error <= 1'b0;
         if (fall) begin
            idle_cnt <= '0;
            if (bit_cnt == 4'd0) begin
               if (dat_s) frame_error <= 1'b1;
               else       bit_cnt     <= 4'd1;
            end else if (bit_cnt <= 4'd8) begin
               shift   <= {dat_s, shift[7:1]};
               bit_cnt <= bit_cnt + 4'd1;
            end else if (bit_cnt == 4'd9) begin
               parity  <= dat_s;
               bit_cnt <= 4'd10;
            end else begin
               if (dat_s && (^{shift, parity})) begin
                  byte_valid <= 1'b1;
                  byte_data  <= shift;
               end else begin
                  frame_error <= 1'b1;
               end
               bit_cnt <= 4'd0;
            end
         end else if (bit_cnt == 4'd0) begin
            idle_cnt <= '0;
         end else if (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            idle_cnt    <= CNT_W'(TIMEOUT_CYCLES);
            bit_cnt     <= 4'd0;
            frame_error <= 1'b1;
         end else if (idle_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_arrow_keys.sv
// PS/2 arrow-key decoder: turns E0-prefixed make/break codes into held flags.
module ps2_arrow_keys
   import doom_kb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       kb_clock,
   input  logic       kb_dat,
   output logic       turn_right,
   output logic       turn_left,
   output logic       move_forward,
   output logic       move_backward,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_error
);

   logic         rx_valid;
   logic [7:0]   rx_data;
   logic         rx_error;
   kb_state_t    state_q, state_d;
   arrow_flags_t flags_q, flags_d;
   arrow_flags_t mask;

   ps2_rx_frame #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
   ) u_rx (
      .clock       (clock),
      .reset       (reset),
      .kb_clock    (kb_clock),
      .kb_dat      (kb_dat),
      .byte_valid  (rx_valid),
      .byte_data   (rx_data),
      .frame_error (rx_error)
   );

   assign byte_valid    = rx_valid;
   assign byte_data     = rx_data;
   assign frame_error   = rx_error;
   assign move_forward  = flags_q.up;
   assign move_backward = flags_q.down;
   assign turn_left     = flags_q.left;
   assign turn_right    = flags_q.right;

   // Decoder state and held-key flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
      end
   end

   // Next state and flag update; advances only on a good byte.
   always_comb begin
      state_d = state_q;
      flags_d = flags_q;
      mask    = arrow_mask(rx_data);
      if (rx_error) begin
         state_d = IDLE;
      end else if (rx_valid) begin
         case (state_q)
            IDLE: begin
               if (rx_data == SC_EXT)      state_d = EXT;
               else if (rx_data == SC_BRK) state_d = BRK;
               else                        state_d = IDLE;
            end
            EXT: begin
               if (rx_data == SC_BRK) begin
                  state_d = EXT_BRK;
               end else if (mask != '0) begin
                  flags_d = flags_q | mask;
                  state_d = IDLE;
               end else if (rx_data == SC_EXT) begin
                  state_d = EXT;
               end else begin
                  state_d = IDLE;
               end
            end
            EXT_BRK: begin
               flags_d = flags_q & ~mask;
               state_d = IDLE;
            end
            BRK:     state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_arrow_keys.sv
// Bench for ps2_arrow_keys: table of frames with expected flags, a pulse
// scoreboard, and hand sequences for start error, timeout and mid-frame reset.
module tb_ps2_arrow_keys;

   localparam int unsigned TO   = 400;
   localparam int unsigned HALF = 20;
   localparam int unsigned GAP  = 10;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       kb_clock = 1'b1;
   logic       kb_dat = 1'b1;
   logic       turn_right, turn_left, move_forward, move_backward;
   logic       byte_valid, frame_error;
   logic [7:0] byte_data;

   ps2_arrow_keys #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
      .clock         (clock),
      .reset         (reset),
      .kb_clock      (kb_clock),
      .kb_dat        (kb_dat),
      .turn_right    (turn_right),
      .turn_left     (turn_left),
      .move_forward  (move_forward),
      .move_backward (move_backward),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .frame_error   (frame_error)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       err;
      logic [7:0] data;
   } evt_t;

   typedef struct {
      logic [7:0] data;
      logic       bad;
      logic [3:0] flags;   // {up, down, left, right}
   } vec_t;

   evt_t       exp_q[$];
   vec_t       vecs[$];
   int         checks = 0;
   int         passes = 0;
   int         cyc = 0;
   int         last_evt_cyc = -100;
   logic [3:0] prev_flags = 4'b0;
   logic [7:0] last_good = 8'h00;

   function automatic logic [3:0] cur_flags();
      return {move_forward, move_backward, turn_left, turn_right};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      else
         passes++;
   endtask

   // One clock, sampled on the falling edge; scoreboard and flag latency live here.
   task automatic tick();
      evt_t e;
      @(negedge clock);
      cyc++;
      if (!reset) begin
         if (byte_valid || frame_error) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", {30'd0, byte_valid, frame_error}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("evt_kind", {30'd0, byte_valid, frame_error}, e.err ? 32'd1 : 32'd2);
               if (!e.err) chk("evt_data", {24'd0, byte_data}, {24'd0, e.data});
            end
            last_evt_cyc = cyc;
         end
         if (cur_flags() != prev_flags)
            chk("flag_latency", cyc - last_evt_cyc, 32'd1);
      end
      prev_flags = cur_flags();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Drive the first nbits of an 11-bit frame, LSB (start bit) first.
   task automatic send_raw(input logic [10:0] fr, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         kb_dat = fr[i];
         ticks(HALF);
         kb_clock = 1'b0;
         ticks(HALF);
         kb_clock = 1'b1;
      end
      kb_dat = 1'b1;
   endtask

   function automatic logic [10:0] frame_of(input logic [7:0] d, input logic bad);
      logic par;
      par = bad ? (^d) : ~(^d);
      return {1'b1, par, d, 1'b0};
   endfunction

   task automatic send_frame(input logic [7:0] d, input logic bad);
      evt_t e;
      e.err  = bad;
      e.data = d;
      exp_q.push_back(e);
      send_raw(frame_of(d, bad), 11);
      ticks(GAP);
      if (!bad) last_good = d;
   endtask

   task automatic add(input logic [7:0] d, input logic bad, input logic [3:0] f);
      vec_t v;
      v.data = d; v.bad = bad; v.flags = f;
      vecs.push_back(v);
   endtask

   task automatic check_idle_outputs(input string tag, input logic [3:0] f);
      chk({tag, "_flags"}, {28'd0, cur_flags()}, {28'd0, f});
      chk({tag, "_data"}, {24'd0, byte_data}, {24'd0, last_good});
      chk({tag, "_pending"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      // flags column is {up, down, left, right} after the frame completes
      add(8'hE0, 0, 4'b0000); add(8'h75, 0, 4'b1000);
      add(8'hE0, 0, 4'b1000); add(8'hF0, 0, 4'b1000); add(8'h75, 0, 4'b0000);
      add(8'hE0, 0, 4'b0000); add(8'h6B, 0, 4'b0010);
      add(8'hE0, 0, 4'b0010); add(8'h74, 0, 4'b0011);
      add(8'hE0, 0, 4'b0011); add(8'hF0, 0, 4'b0011); add(8'h6B, 0, 4'b0001);
      add(8'h72, 1, 4'b0001);
      add(8'hE0, 0, 4'b0001); add(8'h72, 0, 4'b0101);
      add(8'hE0, 0, 4'b0101); add(8'h75, 0, 4'b1101);
      add(8'hE0, 0, 4'b1101); add(8'h75, 0, 4'b1101);
      add(8'h75, 0, 4'b1101); add(8'h6B, 0, 4'b1101);
      add(8'hF0, 0, 4'b1101); add(8'h74, 0, 4'b1101);
      add(8'hE0, 0, 4'b1101); add(8'hE0, 0, 4'b1101); add(8'h6B, 0, 4'b1111);
      add(8'hE0, 0, 4'b1111); add(8'hF0, 0, 4'b1111); add(8'h72, 0, 4'b1011);
      add(8'hE0, 0, 4'b1011); add(8'hF0, 0, 4'b1011); add(8'h74, 0, 4'b1010);
      add(8'hE0, 0, 4'b1010); add(8'hF0, 0, 4'b1010); add(8'h6B, 0, 4'b1000);
      add(8'hE0, 0, 4'b1000); add(8'h74, 1, 4'b1000); add(8'h74, 0, 4'b1000);

      ticks(4);
      reset = 1'b0;
      tick();
      check_idle_outputs("reset", 4'b0000);
      chk("reset_valid", {31'd0, byte_valid}, 32'd0);
      chk("reset_err", {31'd0, frame_error}, 32'd0);

      foreach (vecs[i]) begin
         send_frame(vecs[i].data, vecs[i].bad);
         check_idle_outputs($sformatf("vec%0d", i), vecs[i].flags);
      end

      // start bit sampled high: one error, receiver stays at bit 0
      begin
         evt_t e;
         e.err = 1'b1; e.data = 8'h00;
         exp_q.push_back(e);
         send_raw(11'h7FF, 1);
         ticks(GAP);
         check_idle_outputs("start_err", 4'b1000);
         chk("start_err_bitcnt", {28'd0, dut.u_rx.bit_cnt}, 32'd0);
      end

      // partial frame after a prefix times out once and returns decoder to IDLE
      send_frame(8'hE0, 0);
      begin
         evt_t e;
         e.err = 1'b1; e.data = 8'h00;
         exp_q.push_back(e);
         send_raw(frame_of(8'h74, 0), 5);
         ticks(TO + 60);
         check_idle_outputs("timeout", 4'b1000);
         chk("timeout_bitcnt", {28'd0, dut.u_rx.bit_cnt}, 32'd0);
      end
      send_frame(8'h74, 0);
      check_idle_outputs("after_to_bare", 4'b1000);
      send_frame(8'hE0, 0);
      send_frame(8'h74, 0);
      check_idle_outputs("after_to_ext", 4'b1001);

      // reset in the middle of a frame while flags are set
      send_raw(frame_of(8'hE0, 0), 4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      last_good = 8'h00;
      chk("midrst_flags", {28'd0, cur_flags()}, 32'd0);
      chk("midrst_data", {24'd0, byte_data}, 32'd0);
      chk("midrst_valid", {31'd0, byte_valid}, 32'd0);
      chk("midrst_err", {31'd0, frame_error}, 32'd0);
      chk("midrst_bitcnt", {28'd0, dut.u_rx.bit_cnt}, 32'd0);
      ticks(GAP);
      send_frame(8'hE0, 0);
      send_frame(8'h75, 0);
      check_idle_outputs("after_rst", 4'b1000);

      ticks(GAP);
      chk("final_pending", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
